// File: rtl/register_file_mp_if.sv
// Register-file port bundle: decode-side reads/issue, writeback-side writes, scoreboard view.
// The master modport drives selects, writes, issue and flush; the slave is the register file.
interface register_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]     rsel;
  logic [NRD*DATA_W-1:0] rdat;
  logic [NRD-1:0]        rbusy;
  logic [NWR-1:0]        wen;
  logic [NWR*AW-1:0]     wsel;
  logic [NWR*DATA_W-1:0] wdat;
  logic                  iss_en;
  logic [AW-1:0]         iss_sel;
  logic                  flush;
  logic [NREGS-1:0]      busy_vec;

  modport master (
    output rsel, wen, wsel, wdat, iss_en, iss_sel, flush,
    input  rdat, rbusy, busy_vec
  );

  modport slave (
    input  rsel, wen, wsel, wdat, iss_en, iss_sel, flush,
    output rdat, rbusy, busy_vec
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file with same-cycle write bypass and a pending-write scoreboard.
// Reads are zero-latency combinational; writes and scoreboard updates commit at posedge; no backpressure.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  register_file_mp_if.slave rf
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NREGS-1:0]             busy_q, busy_d;

  // Later write ports overwrite earlier ones, so the highest index wins on a collision.
  always_comb begin : next_state
    logic [AW-1:0] ws;
    regs_d = regs_q;
    busy_d = busy_q;
    ws     = '0;
    for (int j = 0; j < NWR; j++) begin
      ws = rf.wsel[j*AW +: AW];
      if (rf.wen[j] && !(ZERO_REG && ws == '0)) begin
        regs_d[ws] = rf.wdat[j*DATA_W +: DATA_W];
        busy_d[ws] = 1'b0;
      end
    end
    // A new producer supersedes the retiring one; flush drops everything including the issue.
    if (rf.flush) begin
      busy_d = '0;
    end else if (rf.iss_en && !(ZERO_REG && rf.iss_sel == '0)) begin
      busy_d[rf.iss_sel] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin : read_ports
    logic [AW-1:0]     rs;
    logic              hit;
    logic [DATA_W-1:0] bdat;
    rf.rdat  = '0;
    rf.rbusy = '0;
    rs       = '0;
    hit      = 1'b0;
    bdat     = '0;
    for (int i = 0; i < NRD; i++) begin
      rs   = rf.rsel[i*AW +: AW];
      hit  = 1'b0;
      bdat = '0;
      for (int j = 0; j < NWR; j++) begin
        if (BYPASS && rf.wen[j] && rf.wsel[j*AW +: AW] == rs && !(ZERO_REG && rs == '0)) begin
          hit  = 1'b1;
          bdat = rf.wdat[j*DATA_W +: DATA_W];
        end
      end
      // A bypassed value is already available, so it is never reported busy.
      rf.rdat[i*DATA_W +: DATA_W] = hit ? bdat : regs_q[rs];
      rf.rbusy[i]                 = busy_q[rs] && !hit;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign rf.busy_vec = busy_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_register_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;

  logic CLK;
  logic nRST;

  // Instance a: 2R/2W with bypass; instance b: 2R/1W without bypass.
  register_file_mp_if #(.DATA_W(DW), .NREGS(32), .NRD(2), .NWR(2)) ifa ();
  register_file_mp_if #(.DATA_W(DW), .NREGS(32), .NRD(2), .NWR(1)) ifb ();

  register_file_mp #(.DATA_W(DW), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b1), .ZERO_REG(1'b1))
    dut_a (.CLK(CLK), .nRST(nRST), .rf(ifa.slave));
  register_file_mp #(.DATA_W(DW), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(1'b0), .ZERO_REG(1'b1))
    dut_b (.CLK(CLK), .nRST(nRST), .rf(ifb.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum int {K_RDAT0, K_RDAT1, K_RBUSY, K_BVEC, K_B_RDAT1} kind_e;

  int          q_kind[$];
  logic [31:0] q_exp[$];
  string       q_name[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic logic [31:0] observe(int k);
    case (k)
      K_RDAT0:   return ifa.rdat[0 +: DW];
      K_RDAT1:   return ifa.rdat[DW +: DW];
      K_RBUSY:   return {30'd0, ifa.rbusy};
      K_BVEC:    return ifa.busy_vec;
      K_B_RDAT1: return ifb.rdat[DW +: DW];
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  always @(negedge CLK) begin
    while (q_kind.size() > 0) begin
      int          k;
      logic [31:0] e;
      logic [31:0] a;
      string       nm;
      k  = q_kind.pop_front();
      e  = q_exp.pop_front();
      nm = q_name.pop_front();
      a  = observe(k);
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, a, e);
      end
    end
  end

  task automatic expect_val(input kind_e k, input string nm, input logic [31:0] v);
    q_kind.push_back(int'(k));
    q_exp.push_back(v);
    q_name.push_back(nm);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    ifa.rsel = '0; ifa.wen = '0; ifa.wsel = '0; ifa.wdat = '0;
    ifa.iss_en = 1'b0; ifa.iss_sel = '0; ifa.flush = 1'b0;
    ifb.rsel = '0; ifb.wen = '0; ifb.wsel = '0; ifb.wdat = '0;
    ifb.iss_en = 1'b0; ifb.iss_sel = '0; ifb.flush = 1'b0;
  endtask

  task automatic rd_a(input int p, input logic [AW-1:0] r);
    ifa.rsel[p*AW +: AW] = r;
  endtask

  task automatic wr_a(input int p, input logic [AW-1:0] r, input logic [DW-1:0] d);
    ifa.wen[p]             = 1'b1;
    ifa.wsel[p*AW +: AW]   = r;
    ifa.wdat[p*DW +: DW]   = d;
  endtask

  task automatic iss_a(input logic [AW-1:0] r);
    ifa.iss_en  = 1'b1;
    ifa.iss_sel = r;
  endtask

  initial begin
    nRST = 1'b0;
    clr();
    step();
    // Reset state
    rd_a(0, 5); rd_a(1, 7);
    expect_val(K_RDAT0, "reset_rdat0", 32'h0);
    expect_val(K_RDAT1, "reset_rdat1", 32'h0);
    expect_val(K_RBUSY, "reset_rbusy", 32'h0);
    expect_val(K_BVEC,  "reset_busy_vec", 32'h0);
    step();
    nRST = 1'b1;

    // 1: write r5, read back on both ports, then asynchronous reset
    step(); clr();
    wr_a(0, 5, 32'hDEADBEEF); rd_a(0, 5); rd_a(1, 5);
    expect_val(K_RDAT0, "t1_bypass_rdat0", 32'hDEADBEEF);
    step(); clr();
    rd_a(0, 5); rd_a(1, 5);
    expect_val(K_RDAT0, "t1_r5_rdat0", 32'hDEADBEEF);
    expect_val(K_RDAT1, "t1_r5_rdat1", 32'hDEADBEEF);
    step();
    nRST = 1'b0;
    #1;
    expect_val(K_RDAT0, "t1_async_reset_rdat0", 32'h0);
    expect_val(K_RDAT1, "t1_async_reset_rdat1", 32'h0);
    step();
    nRST = 1'b1;

    // 2: same-cycle bypass on a, registered visibility on b
    step(); clr();
    wr_a(0, 7, 32'h1234); rd_a(1, 7);
    ifb.wen[0] = 1'b1; ifb.wsel[0 +: AW] = 5'd7; ifb.wdat[0 +: DW] = 32'h1234;
    ifb.rsel[AW +: AW] = 5'd7;
    expect_val(K_RDAT1,   "t2_bypass_rdat1", 32'h1234);
    expect_val(K_B_RDAT1, "t2_nobypass_old", 32'h0);
    step(); clr();
    rd_a(1, 7); ifb.rsel[AW +: AW] = 5'd7;
    expect_val(K_RDAT1,   "t2_r7_rdat1", 32'h1234);
    expect_val(K_B_RDAT1, "t2_nobypass_new", 32'h1234);

    // 3: zero register ignores writes and issues
    step(); clr();
    wr_a(0, 0, 32'hFFFFFFFF); iss_a(0); rd_a(0, 0);
    expect_val(K_RDAT0, "t3_r0_bypass_blocked", 32'h0);
    expect_val(K_RBUSY, "t3_r0_rbusy_same", 32'h0);
    step(); clr();
    rd_a(0, 0);
    expect_val(K_RDAT0, "t3_r0_rdat", 32'h0);
    expect_val(K_BVEC,  "t3_busy_vec", 32'h0);
    expect_val(K_RBUSY, "t3_r0_rbusy", 32'h0);

    // 4: scoreboard set, clear via write, set beats same-cycle clear
    step(); clr();
    iss_a(3);
    step(); clr();
    rd_a(0, 3);
    expect_val(K_BVEC,  "t4_busy_after_issue", 32'h0000_0008);
    expect_val(K_RBUSY, "t4_rbusy_r3", 32'h1);
    step(); clr();
    wr_a(0, 3, 32'h33); rd_a(0, 3);
    expect_val(K_RBUSY, "t4_rbusy_bypassed", 32'h0);
    expect_val(K_RDAT0, "t4_rdat_bypassed", 32'h33);
    expect_val(K_BVEC,  "t4_busy_pre_edge", 32'h0000_0008);
    step(); clr();
    rd_a(0, 3);
    expect_val(K_BVEC,  "t4_busy_cleared", 32'h0);
    expect_val(K_RDAT0, "t4_r3_value", 32'h33);
    step(); clr();
    iss_a(3); wr_a(0, 3, 32'h44); rd_a(0, 3);
    expect_val(K_RBUSY, "t4_iss_wr_rbusy", 32'h0);
    step(); clr();
    rd_a(0, 3);
    expect_val(K_BVEC,  "t4_set_beats_clear", 32'h0000_0008);
    expect_val(K_RBUSY, "t4_rbusy_again", 32'h1);
    expect_val(K_RDAT0, "t4_r3_new_value", 32'h44);

    // 5: two ports write r9, highest port wins
    step(); clr();
    wr_a(0, 9, 32'hAAAA); wr_a(1, 9, 32'h5555); rd_a(1, 9);
    expect_val(K_RDAT1, "t5_bypass_priority", 32'h5555);
    step(); clr();
    rd_a(1, 9);
    expect_val(K_RDAT1, "t5_write_priority", 32'h5555);

    // 6: issue r1, r2, r4 then flush with a dropped issue and a committed write
    step(); clr(); iss_a(1);
    step(); clr(); iss_a(2);
    step(); clr(); iss_a(4);
    step(); clr();
    expect_val(K_BVEC, "t6_busy_before_flush", 32'h0000_001E);
    ifa.flush = 1'b1; iss_a(6); wr_a(0, 10, 32'h77); rd_a(0, 6);
    expect_val(K_RBUSY, "t6_r6_not_busy_pre", 32'h0);
    step(); clr();
    rd_a(0, 6); rd_a(1, 10);
    expect_val(K_BVEC,  "t6_busy_flushed", 32'h0);
    expect_val(K_RBUSY, "t6_rbusy_after_flush", 32'h0);
    expect_val(K_RDAT1, "t6_r10_written", 32'h77);

    step(); clr();
    step();
    n_chk++;
    if (q_kind.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_kind.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
